rev_map_pipe: RTL and testbench
===============================

Name: rev_map_pipe

Overview:
- Registered, parametrised successor of the combinational per-byte SERDES bit-reorder map.
- Splits a LANES×LANE_W word into lanes and applies a runtime-selectable bit map per lane: identity, interleave, de-interleave or full reverse.
- Sits between the SERDES parallel data path and the framing logic.
- Adds valid/ready flow control with a 2-entry skid buffer, a safe mode-change protocol and an output beat counter.

Parameters:
- LANES, 4, number of lanes per word.
- LANE_W, 8, bits per lane; must be even and at least 2. Elaboration error otherwise.
- CNT_W, 32, width of the output beat counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept an input beat.
- s_data  input  LANES*LANE_W  input word; lane i is bits [i*LANE_W +: LANE_W].
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the output beat.
- m_data  output  LANES*LANE_W  mapped word.
- cfg_load  input  1  one-cycle strobe; load cfg_mode.
- cfg_mode  input  2  requested mode: 0 identity, 1 interleave, 2 de-interleave, 3 reverse.
- mode  output  2  currently active mode.
- cnt_clr  input  1  synchronous clear of beat_cnt.
- beat_cnt  output  CNT_W  count of output handshakes; wraps.

Behaviour:
- Reset values (asynchronous, rst_n low): m_valid=0, m_data=0, s_ready=0 while rst_n is low. s_ready becomes 1 on the first clk edge after release. mode=0, beat_cnt=0, skid buffer empty. Any in-flight beats are discarded.
- Lane maps, with H=LANE_W/2 and applied independently to every lane:
  - Mode 1 (interleave): out[W-1-2k]=in[k] and out[W-2-2k]=in[k+H], for k=0..H-1.
  - Mode 2 (de-interleave): exact inverse of mode 1, out[k]=in[W-1-2k] and out[k+H]=in[W-2-2k].
  - Mode 3 (reverse): out[j]=in[W-1-j].
  - Mode 0: out=in.
- Mode binding:
  - The map is applied when a beat is accepted (s_valid & s_ready), using the mode active in that cycle.
  - The mapped word is stored, so later mode changes never alter beats already accepted.
- cfg_load:
  - mode <= cfg_mode at the next clk edge.
  - If a beat is accepted in the same cycle as cfg_load, that beat uses the old mode. The next accepted beat uses the new mode.
  - Back-to-back cfg_load strobes: the last one wins.
- Datapath: an output register plus one skid register.
  - Latency: an accepted beat appears on m_data with m_valid=1 in the following cycle when the output register is empty or draining.
  - Throughput: 1 beat per clk with m_ready held high.
  - s_ready = skid empty. It is a registered signal with no combinational path from m_ready.
  - When m_valid=1 and m_ready=0, an accepted beat goes to the skid register and s_ready falls the next cycle.
  - When the output drains, the skid contents move to the output register and s_ready rises the next cycle.
  - Ordering is strictly preserved. No beat is dropped or duplicated.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Counter:
  - beat_cnt increments on m_valid & m_ready and wraps from 2^CNT_W-1 to 0.
  - cnt_clr has priority: if it coincides with a handshake, the result is beat_cnt=0, not 1.
- Reset asserted mid-transfer: all state clears immediately, and m_valid drops without waiting for a clk edge.

Test Plan:
- Mode 1, LANES=4, LANE_W=8: s_data=0x0F0F0F0F → m_data=0xAAAAAAAA one cycle later; s_data=0xF0F0F0F0 → 0x55555555.
- Mode 2: s_data=0xAAAAAAAA → 0x0F0F0F0F. A random stream through mode 1 then mode 2 returns the original words.
- Mode 3: s_data=0x12345678 → 0x482C6A1E; mode 0: 0x12345678 → 0x12345678.
- Backpressure:
  - Send 4 beats with m_ready=0 → m_valid=1, the first beat is held and the second is in skid.
  - s_ready=0 from the cycle after the second acceptance.
  - Release m_ready → all beats arrive in order and beat_cnt=4.
- Mode change: cfg_load with cfg_mode=3 coincident with acceptance of 0x01010101 in mode 1 → that beat outputs 0x80808080 (mode 1). The next beat 0x01010101 outputs 0x80808080 (mode 3). A following beat 0x0F0F0F0F in mode 3 outputs 0xF0F0F0F0.
- Counter and reset:
  - CNT_W=4 with 17 handshakes → beat_cnt=1.
  - cnt_clr coincident with a handshake → 0.
  - rst_n low while m_valid=1 → m_valid=0, mode=0 and beat_cnt=0 asynchronously.

Source files
------------

// File: rtl/rev_map_pipe.sv
// rev_map_pipe: registered per-lane bit reorder (identity / interleave /
// de-interleave / reverse) between the SERDES parallel path and framing.
// Valid/ready flow control through an output register plus one skid
// register, mode changes that bind at beat acceptance, and an output beat
// counter.
module rev_map_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*LANE_W-1:0]   s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*LANE_W-1:0]   m_data,
  input  logic                      cfg_load,
  input  logic [1:0]                cfg_mode,
  output logic [1:0]                mode,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          beat_cnt
);

  localparam int DW = LANES * LANE_W;
  localparam int H  = LANE_W / 2;

  // Interleave pairs bit k with bit k+H, so an odd or sub-2 lane is meaningless.
  if ((LANE_W < 2) || ((LANE_W % 2) != 0)) begin : g_bad_lane_w
    $error("rev_map_pipe: LANE_W must be even and at least 2");
  end

  typedef enum logic [1:0] {
    MODE_IDENT = 2'd0,
    MODE_ILV   = 2'd1,
    MODE_DILV  = 2'd2,
    MODE_REV   = 2'd3
  } mode_e;

  // One lane through the selected bit map.
  function automatic logic [LANE_W-1:0] map_lane(input mode_e m,
                                                 input logic [LANE_W-1:0] lane_in);
    logic [LANE_W-1:0] lane_out;
    lane_out = lane_in;
    case (m)
      MODE_ILV: begin
        for (int k = 0; k < H; k++) begin
          lane_out[LANE_W-1-2*k] = lane_in[k];
          lane_out[LANE_W-2-2*k] = lane_in[k+H];
        end
      end
      MODE_DILV: begin
        for (int k = 0; k < H; k++) begin
          lane_out[k]   = lane_in[LANE_W-1-2*k];
          lane_out[k+H] = lane_in[LANE_W-2-2*k];
        end
      end
      MODE_REV: begin
        for (int j = 0; j < LANE_W; j++) begin
          lane_out[j] = lane_in[LANE_W-1-j];
        end
      end
      default: lane_out = lane_in;
    endcase
    return lane_out;
  endfunction

  // Whole word: every lane mapped independently with the same mode.
  function automatic logic [DW-1:0] map_word(input mode_e m, input logic [DW-1:0] word_in);
    logic [DW-1:0] word_out;
    word_out = '0;
    for (int i = 0; i < LANES; i++) begin
      word_out[i*LANE_W +: LANE_W] = map_lane(m, word_in[i*LANE_W +: LANE_W]);
    end
    return word_out;
  endfunction

  mode_e            mode_q,       mode_d;
  logic             m_valid_q,    m_valid_d;
  logic [DW-1:0]    m_data_q,     m_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DW-1:0]    skid_data_q,  skid_data_d;
  logic             s_ready_q,    s_ready_d;
  logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;

  logic             accept;
  logic             handshake;
  logic             out_free;
  logic [DW-1:0]    mapped;

  // Handshake qualifiers and the word mapped with the mode active this cycle.
  always_comb begin
    accept    = s_valid & s_ready_q;
    handshake = m_valid_q & m_ready;
    out_free  = ~m_valid_q | m_ready;
    mapped    = map_word(mode_q, s_data);
  end

  // Mode register input: last strobe wins; the accepted beat already used mode_q.
  always_comb begin
    mode_d = mode_q;
    if (cfg_load) begin
      mode_d = mode_e'(cfg_mode);
    end
  end

  // Output register / skid register steering; s_ready tracks next skid state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // Older beat in skid goes out first; a new beat takes its place.
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = mapped;
        end
      end else begin
        m_valid_d = accept;
        if (accept) begin
          m_data_d = mapped;
        end
      end
    end else if (accept) begin
      // Output stalled: park the beat in skid, output stays stable.
      skid_valid_d = 1'b1;
      skid_data_d  = mapped;
    end
    s_ready_d = ~skid_valid_d;
  end

  // Beat counter: clear wins over a coincident handshake; wraps naturally.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (cnt_clr) begin
      beat_cnt_d = '0;
    end else if (handshake) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any in-flight beats immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too; m_data must read 0 in reset and they are few flops.
      mode_q       <= MODE_IDENT;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      mode_q       <= mode_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign mode     = mode_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_rev_map_pipe.sv
// Directed bench for rev_map_pipe (LANES=4, LANE_W=8, CNT_W=4).
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_rev_map_pipe;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 4;
  localparam int DW     = LANES * LANE_W;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic             cfg_load;
  logic [1:0]       cfg_mode;
  logic [1:0]       mode;
  logic             cnt_clr;
  logic [CNT_W-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  rev_map_pipe #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .cfg_load (cfg_load),
    .cfg_mode (cfg_mode),
    .mode     (mode),
    .cnt_clr  (cnt_clr),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Load a mode with a one-cycle strobe; called and returns at a falling edge.
  task automatic set_mode(input logic [1:0] m);
    cfg_load = 1'b1;
    cfg_mode = m;
    @(negedge clk);
    cfg_load = 1'b0;
    check("set_mode", mode, m);
  endtask

  // Present one beat for a single cycle and return the word on m_data after it.
  task automatic send_beat(input string tag, input logic [DW-1:0] din,
                           output logic [DW-1:0] dout);
    check({tag, "_rdy"}, s_ready, 1);
    s_valid = 1'b1;
    s_data  = din;
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_mv"}, m_valid, 1);
    dout = m_data;
  endtask

  task automatic xfer(input string tag, input logic [DW-1:0] din, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    send_beat(tag, din, got);
    check(tag, got, exp);
  endtask

  logic [DW-1:0] orig  [4];
  logic [DW-1:0] inter [4];
  logic [DW-1:0] tmp;

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    cfg_load = 1'b0;
    cfg_mode = 2'd0;
    cnt_clr  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mv",    m_valid,  0);
    check("rst_sr",    s_ready,  0);
    check("rst_md",    m_data,   0);
    check("rst_mode",  mode,     0);
    check("rst_cnt",   beat_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_sr", s_ready, 1);

    // Interleave, de-interleave, reverse, identity
    set_mode(2'd1);
    xfer("ilv_0f", 32'h0F0F0F0F, 32'hAAAAAAAA);
    xfer("ilv_f0", 32'hF0F0F0F0, 32'h55555555);
    set_mode(2'd2);
    xfer("dilv_aa", 32'hAAAAAAAA, 32'h0F0F0F0F);
    set_mode(2'd3);
    xfer("rev", 32'h12345678, 32'h482C6A1E);
    set_mode(2'd0);
    xfer("ident", 32'h12345678, 32'h12345678);

    // Round trip: interleave then de-interleave returns the original words
    for (int i = 0; i < 4; i++) orig[i] = $urandom;
    set_mode(2'd1);
    for (int i = 0; i < 4; i++) send_beat("rt_fwd", orig[i], inter[i]);
    set_mode(2'd2);
    for (int i = 0; i < 4; i++) xfer("rt_back", inter[i], orig[i]);

    // Clear coincident with a handshake yields zero
    set_mode(2'd0);
    xfer("pre_clr", 32'h11111111, 32'h11111111);
    check("clr_hs_mv", m_valid, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_prio", beat_cnt, 0);

    // Backpressure: A in output, B in skid, C/D waiting
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA0A0A0A0;
    @(negedge clk);
    check("bp_a_mv", m_valid, 1);
    check("bp_a_md", m_data, 32'hA0A0A0A0);
    check("bp_a_sr", s_ready, 1);
    s_data = 32'hB0B0B0B0;
    @(negedge clk);
    check("bp_sr_low", s_ready, 0);
    check("bp_hold_a", m_data, 32'hA0A0A0A0);
    s_data = 32'hC0C0C0C0;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_md", m_data, 32'hA0A0A0A0);
      check("bp_stall_sr", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_b_md", m_data, 32'hB0B0B0B0);
    check("bp_b_sr", s_ready, 1);
    @(negedge clk);
    check("bp_c_md", m_data, 32'hC0C0C0C0);
    s_data = 32'hD0D0D0D0;
    @(negedge clk);
    check("bp_d_md", m_data, 32'hD0D0D0D0);
    s_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", m_valid, 0);
    check("bp_cnt", beat_cnt, 4);

    // Mode change coincident with acceptance uses the old mode
    set_mode(2'd1);
    cfg_load = 1'b1;
    cfg_mode = 2'd3;
    s_valid  = 1'b1;
    s_data   = 32'h01010101;
    @(negedge clk);
    cfg_load = 1'b0;
    check("mc_old", m_data, 32'h80808080);
    check("mc_mode", mode, 3);
    s_data = 32'h01010101;
    @(negedge clk);
    check("mc_new_01", m_data, 32'h80808080);
    s_data = 32'h0F0F0F0F;
    @(negedge clk);
    check("mc_new_0f", m_data, 32'hF0F0F0F0);
    s_valid = 1'b0;
    // Discriminating case: old mode 1 vs new mode 3 differ for 0x0F
    set_mode(2'd1);
    cfg_load = 1'b1;
    cfg_mode = 2'd3;
    s_valid  = 1'b1;
    s_data   = 32'h0F0F0F0F;
    @(negedge clk);
    cfg_load = 1'b0;
    s_valid  = 1'b0;
    check("mc_old_0f", m_data, 32'hAAAAAAAA);

    // Back-to-back strobes: last wins
    cfg_load = 1'b1;
    cfg_mode = 2'd1;
    @(negedge clk);
    cfg_mode = 2'd2;
    @(negedge clk);
    cfg_load = 1'b0;
    check("b2b_mode", mode, 2);
    xfer("b2b_map", 32'hAAAAAAAA, 32'h0F0F0F0F);

    // Counter wrap: 17 handshakes on a 4-bit counter
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("wrap_clr", beat_cnt, 0);
    set_mode(2'd0);
    for (int i = 0; i < 17; i++) begin
      send_beat("wrap_beat", DW'(i), tmp);
    end
    @(negedge clk);
    check("wrap_cnt", beat_cnt, 1);

    // Asynchronous reset mid-transfer
    set_mode(2'd3);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h12345678;
    @(negedge clk);
    s_valid = 1'b0;
    check("ar_mv_pre", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mv",   m_valid,  0);
    check("ar_mode", mode,     0);
    check("ar_cnt",  beat_cnt, 0);
    check("ar_sr",   s_ready,  0);
    check("ar_md",   m_data,   0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("ar_rel_sr", s_ready, 1);
    check("ar_rel_mv", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
